// File: rtl/la_iopwrseq_pkg.sv
// Shared definitions for the IO ring supply sequencer: FSM state encoding
// and the upper bound on the number of sequenced domains.
package la_iopwrseq_pkg;

  localparam int MAX_STAGES = 8;
  localparam int IDXW       = $clog2(MAX_STAGES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RAMP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ON     = 3'd3,
    ST_DOWN   = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

endpackage

// File: rtl/la_dsync.sv
// Two-flop synchronizer for one asynchronous level input into the core clock.
module la_dsync (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/la_iopwrseq.sv
// IO ring supply sequencer: brings domains up in order with power-good and
// settle gating, tears them down in reverse, and latches timeouts/brown-outs.
module la_iopwrseq
  import la_iopwrseq_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int CNTW   = 8,
  parameter int TMO    = 200
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic              en_i,
  input  logic [STAGES-1:0] pgood_i,
  input  logic [CNTW-1:0]   settle_i,
  input  logic              clr_i,
  output logic [STAGES-1:0] stage_en_o,
  output logic              ready_o,
  output logic              fault_o,
  output logic [IDXW-1:0]   fault_idx_o
);

  localparam logic [CNTW-1:0] TMO_LAST = CNTW'(TMO - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(STAGES - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [STAGES-1:0] stage_en_q, stage_en_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;
  logic [IDXW-1:0]   fault_idx_q, fault_idx_d;
  logic [STAGES-1:0] pg_s, pg_prev_q, pg_fall;
  logic              pg_sel, loss_any, fault_hit;
  logic [IDXW-1:0]   loss_idx, fault_src;

  for (genvar g = 0; g < STAGES; g++) begin : g_sync
    la_dsync u_sync (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .d_i      (pgood_i[g]),
      .q_o      (pg_s[g])
    );
  end

  assign pg_fall = pg_prev_q & ~pg_s;
  assign pg_sel  = |(pg_s & (STAGES'(1) << idx_q));

  // In RAMP the current stage has not yet reported good, so only lower stages count.
  always_comb begin
    loss_any = 1'b0;
    loss_idx = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      if (pg_fall[j] && ((state_q == ST_RAMP) ? (IDXW'(j) < idx_q) : (IDXW'(j) <= idx_q))) begin
        loss_any = 1'b1;
        loss_idx = IDXW'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    stage_en_d  = stage_en_q;
    ready_d     = ready_q;
    fault_d     = fault_q;
    fault_idx_d = fault_idx_q;
    fault_hit   = 1'b0;
    fault_src   = loss_idx;
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          stage_en_d = STAGES'(1);
          idx_d      = '0;
          cnt_d      = '0;
          state_d    = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (loss_any) begin
          fault_hit = 1'b1;
        end else if (!pg_sel && cnt_q == TMO_LAST) begin
          fault_hit = 1'b1;
          fault_src = idx_q;
        end else if (!en_i) begin
          state_d = ST_DOWN;
        end else if (pg_sel) begin
          cnt_d   = settle_i;
          state_d = ST_SETTLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_SETTLE: begin
        // Counter holds the remaining settle cycles; zero means this is the last one.
        if (loss_any) begin
          fault_hit = 1'b1;
        end else if (!en_i) begin
          state_d = ST_DOWN;
        end else if (cnt_q == '0) begin
          if (idx_q == IDX_LAST) begin
            ready_d = 1'b1;
            state_d = ST_ON;
          end else begin
            idx_d      = idx_q + IDX_ONE;
            stage_en_d = (stage_en_q << 1) | STAGES'(1);
            cnt_d      = '0;
            state_d    = ST_RAMP;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ON: begin
        if (loss_any) begin
          fault_hit = 1'b1;
        end else if (!en_i) begin
          ready_d = 1'b0;
          state_d = ST_DOWN;
        end
      end
      ST_DOWN: begin
        if (stage_en_q == '0) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          stage_en_d = stage_en_q >> 1;
        end
      end
      ST_FAULT: begin
        if (clr_i && !en_i) begin
          fault_d = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fault_hit) begin
      state_d     = ST_FAULT;
      fault_d     = 1'b1;
      ready_d     = 1'b0;
      stage_en_d  = '0;
      fault_idx_d = fault_src;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      stage_en_q  <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      fault_idx_q <= '0;
      pg_prev_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      stage_en_q  <= stage_en_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      fault_idx_q <= fault_idx_d;
      pg_prev_q   <= pg_s;
    end
  end

  assign stage_en_o  = stage_en_q;
  assign ready_o     = ready_q;
  assign fault_o     = fault_q;
  assign fault_idx_o = fault_idx_q;

  a_stage_en_therm: assert property (@(posedge clk_i) disable iff (!nreset_i)
    ((stage_en_q + STAGES'(1)) & stage_en_q) == '0);

endmodule

// File: tb/tb_la_iopwrseq.sv
// Randomized bench for la_iopwrseq: each scenario is planned open-loop and the
// expected outputs are derived from event-time arithmetic on the sequencing rules.
module tb_la_iopwrseq;

  localparam int S    = 4;
  localparam int CW   = 8;
  localparam int TMO  = 200;
  localparam int NMAX = 1024;
  localparam int INF  = 1 << 20;
  localparam int OW   = S + 5;

  logic          clk;
  logic          nreset;
  logic          en;
  logic          clr;
  logic [S-1:0]  pgood;
  logic [CW-1:0] settle;
  logic [S-1:0]  stage_en;
  logic          ready;
  logic          fault;
  logic [2:0]    fault_idx;

  la_iopwrseq #(.STAGES(S), .CNTW(CW), .TMO(TMO)) dut (
    .clk_i       (clk),
    .nreset_i    (nreset),
    .en_i        (en),
    .pgood_i     (pgood),
    .settle_i    (settle),
    .clr_i       (clr),
    .stage_en_o  (stage_en),
    .ready_o     (ready),
    .fault_o     (fault),
    .fault_idx_o (fault_idx)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: one expected {stage_en, ready, fault, fault_idx} per cycle
  logic [OW-1:0] exp_q[$];

  logic          pl_en  [NMAX];
  logic          pl_clr [NMAX];
  logic          pl_rst [NMAX];
  logic [S-1:0]  pl_pg  [NMAX];

  // Scenario description: plan indices of input events and derived output event times
  int sv, a, f, b, m, q, fidx, clr1, clr_at, nlen, miss, rdy_at;
  int dly [S];
  int r   [S+1];
  int p   [S];
  logic [S-1:0] bmask;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [S-1:0] therm(input int n);
    logic [S-1:0] v;
    v = '0;
    for (int i = 0; i < S; i++) if (i < n) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int stages_on(input int c);
    int n;
    n = 0;
    for (int i = 0; i < S; i++) if (r[i] <= c) n++;
    return n;
  endfunction

  // Stage i is enabled at r[i]; its pgood rises dly[i] later, takes 2 cycles to
  // cross the synchronizer, 1 to be acted on, then settle+1 cycles of settling.
  task automatic timeline();
    r[0] = a;
    for (int i = 0; i < S; i++) begin
      if (r[i] >= INF || i == miss) begin
        p[i]   = INF;
        r[i+1] = INF;
      end else begin
        p[i]   = r[i] + dly[i];
        r[i+1] = p[i] + 3 + sv;
      end
    end
    rdy_at = r[S];
  endtask

  task automatic paint();
    logic [S-1:0] se;
    logic         rd, ft;
    logic [2:0]   fi;
    exp_q.delete();
    for (int c = 0; c < nlen; c++) begin
      pl_en[c]  = (c >= a) && (c < f);
      pl_clr[c] = (c == clr1) || (c == clr_at);
      pl_rst[c] = (c < m);
      for (int i = 0; i < S; i++)
        pl_pg[c][i] = (c >= p[i]) && !(bmask[i] && c >= b && c <= b + 3);
      if (c >= q)      se = '0;
      else if (c >= f) se = therm(stages_on(f - 1) - (c - f));
      else             se = therm(stages_on(c));
      rd = (c < q) && (c < f) && (c >= rdy_at);
      ft = (c >= q) && (c < clr_at);
      fi = (c >= q) ? 3'(fidx) : 3'd0;
      if (c >= m) exp_q.push_back('0);
      else        exp_q.push_back({se, rd, ft, fi});
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    nreset = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    pgood  = '0;
    settle = CW'(sv);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset", {stage_en, ready, fault, fault_idx}, '0);
    end
  endtask

  task automatic run(input string name);
    do_reset();
    for (int c = 0; c < nlen; c++) begin
      nreset = pl_rst[c];
      en     = pl_en[c];
      clr    = pl_clr[c];
      pgood  = pl_pg[c];
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s c%0d", name, c), {stage_en, ready, fault, fault_idx}, exp_q.pop_front());
    end
  endtask

  task automatic scenario(input int kind, input int it);
    string name;
    int    k;
    f = INF; b = INF; m = INF; q = INF; clr1 = INF; clr_at = INF;
    bmask = '0; miss = -1; fidx = 0;
    a  = int'($urandom_range(1, 4));
    sv = int'($urandom_range(0, 7));
    for (int i = 0; i < S; i++) dly[i] = int'($urandom_range(0, 12));
    if (it == 0) begin
      sv = 3;
      for (int i = 0; i < S; i++) dly[i] = 5;
    end
    case (kind)
      0: begin
        name = "down";
        timeline();
        f    = rdy_at + 1 + int'($urandom_range(0, 8));
        nlen = f + S + 8;
      end
      1: begin
        name = "timeout";
        miss = (it == 0) ? 2 : int'($urandom_range(0, S - 1));
        timeline();
        q      = r[miss] + TMO;
        fidx   = miss;
        clr1   = q + 5;
        f      = q + 10;
        clr_at = q + 15;
        nlen   = clr_at + 6;
      end
      2: begin
        name = "abort";
        timeline();
        f    = p[1] + 3 + int'($urandom_range(0, sv));
        nlen = f + S + 6;
      end
      3: begin
        name  = "brownout";
        bmask = (it == 0) ? S'(2) : S'($urandom_range(1, (1 << S) - 1));
        timeline();
        b = rdy_at + int'($urandom_range(0, 5));
        q = b + 2;
        for (int i = S - 1; i >= 0; i--) if (bmask[i]) fidx = i;
        clr1   = q + 5;
        f      = q + 10;
        clr_at = q + 15;
        nlen   = clr_at + 6;
      end
      default: begin
        name = "rst_ramp";
        sv   = 0;
        timeline();
        k    = int'($urandom_range(0, S - 1));
        m    = int'($urandom_range(r[k] + 1, p[k] + 2));
        nlen = m + 6;
      end
    endcase
    paint();
    run($sformatf("%s%0d", name, it));
  endtask

  initial begin
    nreset = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    pgood  = '0;
    settle = '0;
    for (int it = 0; it < 5; it++)
      for (int kind = 0; kind < 5; kind++)
        scenario(kind, it);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
